// File: rtl/irq_pending_arbiter.sv
// -----------------------------------------------------------------------------
// irq_pending_arbiter
//
// Synchronises eight asynchronous interrupt request lines, captures them into
// a sticky pending register and presents the highest-priority unmasked
// pending line to a consumer through a valid/ack handshake.
//
// Parameters
//   SYNC_STAGES  input synchronizer depth (2 or 3)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (forces outputs immediately)
//   irq_in     asynchronous request lines, bit 7 is highest priority
//   mask       mask[i]=1 keeps line i out of arbitration, not out of pending
//   irq_ack    consumer acknowledge of the presented request
//   irq_valid  a request is presented on irq_id
//   irq_id     binary index of the presented request
//   pending    raw (unmasked) pending register
//
// Build option
//   IRQ_EDGE_DETECT_EN  when defined, a line pends on a 0->1 transition of its
//                       synchronised value; otherwise it pends while high.
// -----------------------------------------------------------------------------
module irq_pending_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Index of the highest set bit; later (higher) bits overwrite earlier ones.
  function automatic logic [2:0] prio_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] sync_out_s;
  logic [7:0] set_ev_s;
  logic [7:0] eligible_s;
  logic [7:0] clr_s;
  logic [7:0] pending_q, pending_d;
  logic       irq_valid_q, irq_valid_d;
  logic [2:0] irq_id_q, irq_id_d;
  state_e     state_q, state_d;

`ifdef IRQ_EDGE_DETECT_EN
  logic [7:0] hist_q, hist_d;

  // Edge mode: pend only on a rising transition of the synchronised line.
  // The history flop resets to 0, so a line high at reset release counts once.
  always_comb begin
    hist_d   = sync_out_s;
    set_ev_s = sync_out_s & ~hist_q;
  end

  // Edge-history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 8'h00;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  // Level mode: a high synchronised line keeps re-pending every cycle.
  always_comb begin
    set_ev_s = sync_out_s;
  end
`endif

  // Synchronizer shift, arbitration FSM and pending-register next state.
  always_comb begin
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    sync_out_s = sync_q[SYNC_STAGES-1];

    eligible_s  = pending_q & ~mask;
    clr_s       = 8'h00;
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;

    case (state_q)
      IDLE: begin
        if (|eligible_s) begin
          irq_id_d    = prio_idx(eligible_s);
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          // irq_id keeps its last value while nothing is presented
          irq_valid_d = 1'b0;
        end
      end
      PRESENT: begin
        // id/valid frozen here regardless of mask or pending changes
        if (irq_ack) begin
          clr_s       = 8'h01 << irq_id_q;
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // a coincident set event beats the ack clear
    pending_d = (pending_q & ~clr_s) | set_ev_s;
  end

  // State, output and synchronizer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      pending_q   <= 8'h00;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 3'd0;
      state_q     <= IDLE;
    end else begin
      sync_q      <= sync_d;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      state_q     <= state_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_arbiter
//
// Directed self-checking bench for irq_pending_arbiter (SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_irq_pending_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int checks_cnt;
  int fail_cnt;

  irq_pending_arbiter #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending)
  );

  // 10-unit clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on irq_in, stopping just after the edge that presents it.
  // Edge1 samples, edge3 pends, edge4 presents (FSM idle, line unmasked).
  task automatic pulse_to_present(input logic [7:0] val);
    irq_in = val;
    tick();
    irq_in = 8'h00;
    tick();
    check("lat_no_pend_e2", {24'd0, pending}, 32'h0);
    tick();
    check("lat_pend_e3", {24'd0, pending}, {24'd0, val});
    tick();
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst     = 1'b1;
    irq_in  = 8'h00;
    mask    = 8'h00;
    irq_ack = 1'b0;

    // reset state before any clock edge
    #2;
    check("rst_valid", {31'd0, irq_valid}, 32'h0);
    check("rst_id", {29'd0, irq_id}, 32'h0);
    check("rst_pend", {24'd0, pending}, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // single request on line 2
    pulse_to_present(8'h04);
    check("single_valid", {31'd0, irq_valid}, 32'h1);
    check("single_id", {29'd0, irq_id}, 32'h2);
    ack_cycle();
    check("single_ack_pend", {24'd0, pending}, 32'h0);
    check("single_ack_valid", {31'd0, irq_valid}, 32'h0);
    tick();
    check("single_idle_valid", {31'd0, irq_valid}, 32'h0);

    // priority: lines 7 and 0 together
    pulse_to_present(8'h81);
    check("prio_first_id", {29'd0, irq_id}, 32'h7);
    check("prio_first_valid", {31'd0, irq_valid}, 32'h1);
    ack_cycle();
    check("prio_gap_valid", {31'd0, irq_valid}, 32'h0);
    check("prio_gap_pend", {24'd0, pending}, 32'h01);
    tick();
    check("prio_second_valid", {31'd0, irq_valid}, 32'h1);
    check("prio_second_id", {29'd0, irq_id}, 32'h0);
    ack_cycle();
    check("prio_done_pend", {24'd0, pending}, 32'h0);
    tick();

    // mask line 7: line 0 goes first, line 7 stays pending
    mask = 8'h80;
    pulse_to_present(8'h81);
    check("mask_id", {29'd0, irq_id}, 32'h0);
    check("mask_pend", {24'd0, pending}, 32'h81);
    ack_cycle();
    check("mask_ack_pend", {24'd0, pending}, 32'h80);
    tick();
    check("mask_blocked_valid", {31'd0, irq_valid}, 32'h0);
    check("mask_hold_id", {29'd0, irq_id}, 32'h0);
    // ack while idle must not touch pending
    ack_cycle();
    check("idle_ack_pend", {24'd0, pending}, 32'h80);
    check("idle_ack_valid", {31'd0, irq_valid}, 32'h0);
    mask = 8'h00;
    tick();
    check("unmask_valid", {31'd0, irq_valid}, 32'h1);
    check("unmask_id", {29'd0, irq_id}, 32'h7);
    ack_cycle();
    check("unmask_done_pend", {24'd0, pending}, 32'h0);
    tick();

    // hold: higher line arrives while 3 is presented
    pulse_to_present(8'h08);
    check("hold_id_start", {29'd0, irq_id}, 32'h3);
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    check("hold_pend", {24'd0, pending}, 32'h48);
    check("hold_id", {29'd0, irq_id}, 32'h3);
    check("hold_valid", {31'd0, irq_valid}, 32'h1);
    ack_cycle();
    check("hold_gap_valid", {31'd0, irq_valid}, 32'h0);
    check("hold_gap_pend", {24'd0, pending}, 32'h40);
    tick();
    check("hold_next_id", {29'd0, irq_id}, 32'h6);
    check("hold_next_valid", {31'd0, irq_valid}, 32'h1);
    ack_cycle();
    check("hold_done_pend", {24'd0, pending}, 32'h0);
    tick();

    // line 1 held high across its ack
    irq_in = 8'h02;
    tick();
    tick();
    tick();
    check("held_pend", {24'd0, pending}, 32'h02);
    tick();
    check("held_id", {29'd0, irq_id}, 32'h1);
    check("held_valid", {31'd0, irq_valid}, 32'h1);
    ack_cycle();
`ifdef IRQ_EDGE_DETECT_EN
    check("held_ack_pend", {24'd0, pending}, 32'h0);
    check("held_ack_valid", {31'd0, irq_valid}, 32'h0);
    tick();
    check("held_no_repres", {31'd0, irq_valid}, 32'h0);
`else
    check("held_ack_pend", {24'd0, pending}, 32'h02);
    check("held_ack_valid", {31'd0, irq_valid}, 32'h0);
    tick();
    check("held_repres_valid", {31'd0, irq_valid}, 32'h1);
    check("held_repres_id", {29'd0, irq_id}, 32'h1);
`endif
    irq_in = 8'h00;
    tick();
    tick();
    ack_cycle();
    check("held_drain_pend", {24'd0, pending}, 32'h0);
    check("held_drain_valid", {31'd0, irq_valid}, 32'h0);
    tick();

    // reset while presenting with 0x0C pending: immediate, no clock edge
    pulse_to_present(8'h0C);
    check("rstmid_pre_id", {29'd0, irq_id}, 32'h3);
    check("rstmid_pre_pend", {24'd0, pending}, 32'h0C);
    rst = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, irq_valid}, 32'h0);
    check("rstmid_pend", {24'd0, pending}, 32'h0);
    check("rstmid_id", {29'd0, irq_id}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_valid", {31'd0, irq_valid}, 32'h0);
    check("post_rst_pend", {24'd0, pending}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
